rtlmem_rdctl: RTL



---
 rtl/rtlmem_rdctl_if.sv | 26 ++
 rtl/rtlmem_rdctl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rtlmem_rdctl_if.sv
// rtlmem_rdctl_if: request/response stream and memory read-port bundle.
// master = requester + memory side, slave = controller (rtlmem_rdctl).
interface rtlmem_rdctl_if #(
  parameter int G_RDADDR  = 10,
  parameter int G_RDWIDTH = 16
);
  logic                 req_vld;
  logic                 req_rdy;
  logic [G_RDADDR-1:0]  req_addr;
  logic                 memre;
  logic [G_RDADDR-1:0]  memra;
  logic [G_RDWIDTH-1:0] memdo;
  logic                 rsp_vld;
  logic                 rsp_rdy;
  logic [G_RDWIDTH-1:0] rsp_dat;

  modport master (
    output req_vld, req_addr, rsp_rdy, memdo,
    input  req_rdy, memre, memra, rsp_vld, rsp_dat
  );

  modport slave (
    input  req_vld, req_addr, rsp_rdy, memdo,
    output req_rdy, memre, memra, rsp_vld, rsp_dat
  );
endinterface

// File: rtl/rtlmem_rdctl.sv
// rtlmem_rdctl: read client for a G_LAT-cycle memory read port.
// Ports: clk, rst (sync, active-high), clrrdy (accept enable),
//   bus (slave: req_vld/req_rdy/req_addr, memre/memra/memdo,
//   rsp_vld/rsp_rdy/rsp_dat). Define RTLMEM_RDCTL_STAT_EN to add
//   stat_rdcnt / stat_stall saturating 32-bit counters.
module rtlmem_rdctl #(
  parameter int G_RDADDR  = 10,
  parameter int G_RDWIDTH = 16,
  parameter int G_LAT     = 2,
  parameter int G_FDEPTH  = 4,
  parameter logic [G_RDWIDTH-1:0] G_RST_VAL = {G_RDWIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clrrdy,
`ifdef RTLMEM_RDCTL_STAT_EN
  output logic [31:0]         stat_rdcnt,
  output logic [31:0]         stat_stall,
`endif
  rtlmem_rdctl_if.slave       bus
);

  localparam int CW = $clog2(G_FDEPTH + 1);
  localparam int PW = (G_FDEPTH > 1) ? $clog2(G_FDEPTH) : 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(G_FDEPTH);
  localparam logic [PW-1:0] C_PLAST = PW'(G_FDEPTH - 1);

  logic [CW-1:0]        r_occ;
  logic [G_LAT-1:0]     r_sr;
  logic [G_RDWIDTH-1:0] r_mem [G_FDEPTH];
  logic [PW-1:0]        r_wp;
  logic [PW-1:0]        r_rp;
  logic [CW-1:0]        r_cnt;

  logic w_rdy;
  logic w_issue;
  logic w_vld;
  logic w_pop;
  logic w_push;

  function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
    return (p == C_PLAST) ? '0 : p + PW'(1);
  endfunction

  // occ covers reads in flight plus stored words, so bounding
  // it by the FIFO depth guarantees every return has a slot.
  assign w_rdy   = clrrdy & ~rst & (r_occ < C_DEPTH);
  assign w_issue = bus.req_vld & w_rdy;
  assign w_vld   = ~rst & (r_cnt != '0);
  assign w_pop   = w_vld & bus.rsp_rdy;
  assign w_push  = r_sr[G_LAT-1];

  assign bus.req_rdy = w_rdy;
  assign bus.memre   = w_issue;
  assign bus.memra   = rst ? '0 : bus.req_addr;
  assign bus.rsp_vld = w_vld;
  assign bus.rsp_dat = rst ? G_RST_VAL : r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= '0;
    end else begin
      unique case ({w_issue, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Valid pipe mirrors memory latency; its tail marks memdo valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= w_issue;
      for (int i = 1; i < G_LAT; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  // Storage is reset so the head word reads G_RST_VAL when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < G_FDEPTH; i++) begin
        r_mem[i] <= G_RST_VAL;
      end
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= bus.memdo;
        r_wp        <= f_nxt(r_wp);
      end
      if (w_pop) begin
        r_rp <= f_nxt(r_rp);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  a_no_ovf: assert property (
    @(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_cnt == C_DEPTH))
  );

`ifdef RTLMEM_RDCTL_STAT_EN
  logic [31:0] r_rdcnt;
  logic [31:0] r_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdcnt <= '0;
      r_stall <= '0;
    end else begin
      if (w_issue && (r_rdcnt != '1)) begin
        r_rdcnt <= r_rdcnt + 32'd1;
      end
      if (bus.req_vld && !w_rdy && (r_stall != '1)) begin
        r_stall <= r_stall + 32'd1;
      end
    end
  end

  assign stat_rdcnt = r_rdcnt;
  assign stat_stall = r_stall;
`endif

endmodule
